// File: rtl/spw_link_fsm_param.sv
// SpaceWire link-initialisation state machine with parametrised timeouts on one shared timer,
// a sticky error-cause register, a saturating error counter and link up/down pulses.
module spw_link_fsm_param #(
    parameter int unsigned T_RESET_CYC = 640,
    parameter int unsigned T_WAIT_CYC  = 1280,
    parameter int unsigned T_DISC_CYC  = 85,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic                auto_start,
    input  logic                link_start,
    input  logic                link_disable,
    input  logic                rx_error,
    input  logic                rx_credit_error,
    input  logic                rx_got_bit,
    input  logic                rx_got_null,
    input  logic                rx_got_nchar,
    input  logic                rx_got_time_code,
    input  logic                rx_got_fct,
    input  logic                err_clear,
    output logic                rx_resetn,
    output logic                enable_tx,
    output logic                send_null_tx,
    output logic                send_fct_tx,
    output logic [5:0]          fsm_state,
    output logic                link_up,
    output logic                link_down,
    output logic [4:0]          err_cause,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [5:0] {
        S_ERROR_RESET = 6'h00,
        S_ERROR_WAIT  = 6'h01,
        S_READY       = 6'h02,
        S_STARTED     = 6'h04,
        S_CONNECTING  = 6'h08,
        S_RUN         = 6'h10
    } state_t;

    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(T_RESET_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(T_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] DISC_LAST  = CNT_W'(T_DISC_CYC - 1);

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    timer;
    logic [CNT_W-1:0]    timer_next;
    logic [4:0]          cause_set;
    logic [4:0]          cause_next;
    logic [ERRCNT_W-1:0] count_base;
    logic [ERRCNT_W-1:0] count_next;
    logic                illegal;
    logic                wait_exp;
    logic                disc_exp;
    logic                enter_err;

    // State, timer and all registered outputs.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state        <= S_ERROR_RESET;
            timer        <= '0;
            rx_resetn    <= 1'b0;
            enable_tx    <= 1'b0;
            send_null_tx <= 1'b0;
            send_fct_tx  <= 1'b0;
            link_up      <= 1'b0;
            link_down    <= 1'b0;
            err_cause    <= '0;
            err_count    <= '0;
        end else begin
            state        <= next_state;
            timer        <= timer_next;
            rx_resetn    <= (next_state != S_ERROR_RESET);
            enable_tx    <= (next_state == S_READY) || (next_state == S_STARTED) ||
                            (next_state == S_CONNECTING) || (next_state == S_RUN);
            send_null_tx <= (next_state == S_STARTED) || (next_state == S_CONNECTING) ||
                            (next_state == S_RUN);
            send_fct_tx  <= (next_state == S_CONNECTING) || (next_state == S_RUN);
            link_up      <= (next_state == S_RUN) && (state != S_RUN);
            link_down    <= (state == S_RUN) && (next_state != S_RUN);
            err_cause    <= cause_next;
            err_count    <= count_next;
        end
    end

    assign fsm_state = state;

    // Next state, timer and error bookkeeping; errors win over progress.
    always_comb begin
        next_state = state;
        cause_set  = '0;
        illegal    = rx_got_fct | rx_got_nchar | rx_got_time_code;
        wait_exp   = (timer == WAIT_LAST);
        disc_exp   = !rx_got_bit && (timer == DISC_LAST);

        case (state)
            S_ERROR_RESET: begin
                if (timer == RESET_LAST) next_state = S_ERROR_WAIT;
            end
            S_ERROR_WAIT: begin
                if (link_disable || rx_error || illegal) begin
                    next_state = S_ERROR_RESET;
                    cause_set  = {link_disable, illegal, 1'b0, 1'b0, rx_error};
                end else if (wait_exp) begin
                    next_state = S_READY;
                end
            end
            S_READY: begin
                if (rx_error || illegal) begin
                    next_state = S_ERROR_RESET;
                    cause_set  = {1'b0, illegal, 1'b0, 1'b0, rx_error};
                end else if (!link_disable && (link_start || (auto_start && rx_got_null))) begin
                    next_state = S_STARTED;
                end
            end
            S_STARTED: begin
                if (link_disable || rx_error || illegal || wait_exp) begin
                    next_state = S_ERROR_RESET;
                    cause_set  = {link_disable, illegal | wait_exp, 1'b0, 1'b0, rx_error};
                end else if (rx_got_null) begin
                    next_state = S_CONNECTING;
                end
            end
            S_CONNECTING: begin
                if (link_disable || rx_error || rx_got_nchar || rx_got_time_code || wait_exp) begin
                    next_state = S_ERROR_RESET;
                    cause_set  = {link_disable, rx_got_nchar | rx_got_time_code | wait_exp,
                                  1'b0, 1'b0, rx_error};
                end else if (rx_got_fct) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (link_disable || rx_error || rx_credit_error || disc_exp) begin
                    next_state = S_ERROR_RESET;
                    cause_set  = {link_disable, 1'b0, disc_exp, rx_credit_error, rx_error};
                end
            end
            default: next_state = S_ERROR_RESET;
        endcase

        // Ready has no timeout, so the timer is held there to rule out wrap-around.
        if (next_state != state)                 timer_next = '0;
        else if (state == S_RUN && rx_got_bit)   timer_next = '0;
        else if (state == S_READY)               timer_next = timer;
        else                                     timer_next = timer + CNT_W'(1);

        enter_err  = (next_state == S_ERROR_RESET) && (state != S_ERROR_RESET);
        cause_next = (err_clear ? 5'b0 : err_cause) | cause_set;
        count_base = err_clear ? '0 : err_count;
        count_next = (enter_err && (count_base != {ERRCNT_W{1'b1}})) ?
                     count_base + ERRCNT_W'(1) : count_base;
    end

endmodule

// File: tb/tb_spw_link_fsm_param.sv
// Directed bench for spw_link_fsm_param: startup, link-up, disconnect, priority,
// connect timeout, error counter saturation, err_clear and mid-run reset.
module tb_spw_link_fsm_param;

    logic       pclk = 1'b0;
    logic       reset, auto_start, link_start, link_disable, rx_error, rx_credit_error;
    logic       rx_got_bit, rx_got_null, rx_got_nchar, rx_got_time_code, rx_got_fct, err_clear;
    logic       rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up, link_down;
    logic [5:0] fsm_state;
    logic [4:0] err_cause;
    logic [1:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    spw_link_fsm_param #(.ERRCNT_W(2)) dut (
        .pclk(pclk), .reset(reset), .auto_start(auto_start), .link_start(link_start),
        .link_disable(link_disable), .rx_error(rx_error), .rx_credit_error(rx_credit_error),
        .rx_got_bit(rx_got_bit), .rx_got_null(rx_got_null), .rx_got_nchar(rx_got_nchar),
        .rx_got_time_code(rx_got_time_code), .rx_got_fct(rx_got_fct), .err_clear(err_clear),
        .rx_resetn(rx_resetn), .enable_tx(enable_tx), .send_null_tx(send_null_tx),
        .send_fct_tx(send_fct_tx), .fsm_state(fsm_state), .link_up(link_up),
        .link_down(link_down), .err_cause(err_cause), .err_count(err_count)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; auto_start = 1'b0; link_start = 1'b1; link_disable = 1'b0;
        rx_error = 1'b0; rx_credit_error = 1'b0; rx_got_bit = 1'b0; rx_got_null = 1'b0;
        rx_got_nchar = 1'b0; rx_got_time_code = 1'b0; rx_got_fct = 1'b0; err_clear = 1'b0;

        // Reset and startup
        tick(3);
        chk("rst_state", 32'(fsm_state), 32'h00);
        chk("rst_resetn", 32'(rx_resetn), 0);
        chk("rst_entx", 32'(enable_tx), 0);
        chk("rst_cause", 32'(err_cause), 0);
        chk("rst_count", 32'(err_count), 0);
        reset = 1'b0;
        tick(639);
        chk("er_dwell", 32'(fsm_state), 32'h00);
        tick(1);
        chk("to_wait", 32'(fsm_state), 32'h01);
        chk("wait_resetn", 32'(rx_resetn), 1);
        chk("wait_entx", 32'(enable_tx), 0);
        tick(1279);
        chk("wait_dwell", 32'(fsm_state), 32'h01);
        tick(1);
        chk("to_ready", 32'(fsm_state), 32'h02);
        chk("ready_entx", 32'(enable_tx), 1);
        chk("ready_null", 32'(send_null_tx), 0);
        tick(1);
        chk("to_started", 32'(fsm_state), 32'h04);
        chk("started_null", 32'(send_null_tx), 1);
        chk("started_fct", 32'(send_fct_tx), 0);
        rx_got_null = 1'b1;
        tick(1);
        rx_got_null = 1'b0;
        chk("to_connecting", 32'(fsm_state), 32'h08);
        chk("conn_fct", 32'(send_fct_tx), 1);

        // Link-up
        tick(5);
        rx_got_fct = 1'b1;
        tick(1);
        rx_got_fct = 1'b0;
        chk("to_run", 32'(fsm_state), 32'h10);
        chk("link_up_set", 32'(link_up), 1);
        chk("run_fct", 32'(send_fct_tx), 1);
        tick(1);
        chk("link_up_clr", 32'(link_up), 0);
        chk("run_count", 32'(err_count), 0);

        // Disconnect: bits every 84 cycles keep run, an 85-cycle gap drops it
        rx_got_bit = 1'b1;
        tick(1);
        rx_got_bit = 1'b0;
        repeat (3) begin
            tick(83);
            rx_got_bit = 1'b1;
            tick(1);
            rx_got_bit = 1'b0;
        end
        chk("run_kept", 32'(fsm_state), 32'h10);
        tick(84);
        chk("run_gap84", 32'(fsm_state), 32'h10);
        tick(1);
        chk("disc_state", 32'(fsm_state), 32'h00);
        chk("disc_down", 32'(link_down), 1);
        chk("disc_cause", 32'(err_cause), 32'h04);
        chk("disc_count", 32'(err_count), 1);
        chk("disc_resetn", 32'(rx_resetn), 0);
        link_start = 1'b0;
        tick(1);
        chk("down_clr", 32'(link_down), 0);
        tick(639);
        chk("p_wait", 32'(fsm_state), 32'h01);
        tick(1280);
        chk("p_ready", 32'(fsm_state), 32'h02);

        // Priority: disable blocks start in ready, nchar beats null in started
        link_disable = 1'b1; link_start = 1'b1;
        tick(3);
        chk("ready_disabled", 32'(fsm_state), 32'h02);
        link_disable = 1'b0;
        tick(1);
        chk("p_started", 32'(fsm_state), 32'h04);
        rx_got_null = 1'b1; rx_got_nchar = 1'b1;
        tick(1);
        rx_got_null = 1'b0; rx_got_nchar = 1'b0; link_start = 1'b0;
        chk("illegal_state", 32'(fsm_state), 32'h00);
        chk("illegal_cause", 32'(err_cause), 32'h0C);
        chk("illegal_count", 32'(err_count), 2);

        // Connect timeout counted from entry to connecting
        tick(640);
        tick(1280);
        chk("c_ready", 32'(fsm_state), 32'h02);
        link_start = 1'b1;
        tick(1);
        link_start = 1'b0;
        tick(10);
        chk("c_started", 32'(fsm_state), 32'h04);
        rx_got_null = 1'b1;
        tick(1);
        rx_got_null = 1'b0;
        chk("c_connecting", 32'(fsm_state), 32'h08);
        tick(1279);
        chk("c_dwell", 32'(fsm_state), 32'h08);
        tick(1);
        chk("c_timeout", 32'(fsm_state), 32'h00);
        chk("c_count", 32'(err_count), 3);

        // Saturation at 3 after five errors
        repeat (2) begin
            tick(640);
            chk("s_wait", 32'(fsm_state), 32'h01);
            rx_error = 1'b1;
            tick(1);
            rx_error = 1'b0;
            chk("s_err", 32'(fsm_state), 32'h00);
        end
        chk("sat_count", 32'(err_count), 3);
        chk("sat_cause", 32'(err_cause), 32'h0D);

        // err_clear alone, then together with a new error
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("clr_cause", 32'(err_cause), 0);
        chk("clr_count", 32'(err_count), 0);
        tick(639);
        chk("clr_wait", 32'(fsm_state), 32'h01);
        err_clear = 1'b1; rx_error = 1'b1;
        tick(1);
        err_clear = 1'b0; rx_error = 1'b0;
        chk("clrerr_cause", 32'(err_cause), 32'h01);
        chk("clrerr_count", 32'(err_count), 1);

        // Reset asserted in run
        tick(640);
        tick(1280);
        link_start = 1'b1;
        tick(1);
        link_start = 1'b0;
        rx_got_null = 1'b1;
        tick(1);
        rx_got_null = 1'b0;
        rx_got_fct = 1'b1;
        tick(1);
        rx_got_fct = 1'b0;
        chk("r_run", 32'(fsm_state), 32'h10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mr_state", 32'(fsm_state), 32'h00);
        chk("mr_resetn", 32'(rx_resetn), 0);
        chk("mr_tx", 32'({enable_tx, send_null_tx, send_fct_tx}), 0);
        chk("mr_pulses", 32'({link_up, link_down}), 0);
        chk("mr_cause", 32'(err_cause), 0);
        chk("mr_count", 32'(err_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
